// File: rtl/general_reg_file_if.sv
// Register-file access bundle: two combinational read ports and one write port.
// The datapath drives addresses and write data; the register file returns read data.
interface general_reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  GRF_WEnable;
  logic [ADDR_WIDTH-1:0] GRF_RAddr1;
  logic [ADDR_WIDTH-1:0] GRF_RAddr2;
  logic [ADDR_WIDTH-1:0] GRF_WAddr;
  logic [DATA_WIDTH-1:0] GRF_WData;
  logic [DATA_WIDTH-1:0] GRF_RData1;
  logic [DATA_WIDTH-1:0] GRF_RData2;

  modport master (
    output GRF_WEnable, GRF_RAddr1, GRF_RAddr2, GRF_WAddr, GRF_WData,
    input  GRF_RData1, GRF_RData2
  );

  modport slave (
    input  GRF_WEnable, GRF_RAddr1, GRF_RAddr2, GRF_WAddr, GRF_WData,
    output GRF_RData1, GRF_RData2
  );
endinterface

// File: rtl/general_reg_file.sv
// 32 x 32 MIPS general register file: $0 hardwired to zero, async active-low clear,
// one clocked write port and two zero-latency read ports with optional write bypass.
module general_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  general_reg_file_if.slave grf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Index 0 has no storage; it reads through the zero entry of rd_bank.
  logic [DATA_WIDTH-1:0] regs_q  [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] regs_d  [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_bank [0:DEPTH-1];
  logic [DEPTH-1:1]      wr_sel;

  assign rd_bank[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      assign wr_sel[gi]  = grf.GRF_WEnable && (grf.GRF_WAddr == ADDR_WIDTH'(gi));
      assign regs_d[gi]  = wr_sel[gi] ? grf.GRF_WData : regs_q[gi];
      assign rd_bank[gi] = regs_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  logic                  hit1, hit2;
  logic [DATA_WIDTH-1:0] rdata1, rdata2;

  generate
    if (BYPASS) begin : g_bypass
      assign hit1 = grf.GRF_WEnable && (grf.GRF_WAddr == grf.GRF_RAddr1) && (grf.GRF_RAddr1 != '0);
      assign hit2 = grf.GRF_WEnable && (grf.GRF_WAddr == grf.GRF_RAddr2) && (grf.GRF_RAddr2 != '0);
    end else begin : g_no_bypass
      assign hit1 = 1'b0;
      assign hit2 = 1'b0;
    end
  endgenerate

  // Gating with reset keeps the outputs at zero in the same instant reset falls,
  // without relying on the ordering of the flop clear.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (reset) begin
      rdata1 = hit1 ? grf.GRF_WData : rd_bank[grf.GRF_RAddr1];
      rdata2 = hit2 ? grf.GRF_WData : rd_bank[grf.GRF_RAddr2];
    end
  end

  assign grf.GRF_RData1 = rdata1;
  assign grf.GRF_RData2 = rdata2;
endmodule

// File: tb/tb_general_reg_file.sv
// Directed bench for general_reg_file: stimulus pushes expected read data into a
// queue, a separate monitor pops each entry and compares it with both read ports.
module tb_general_reg_file;
  logic clk;
  logic reset;

  general_reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) grf_if ();

  general_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .grf   (grf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t exp_q[$];
  event push_ev;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push_exp(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
    -> push_ev;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(push_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (grf_if.GRF_RData1 !== e.e1 || grf_if.GRF_RData2 !== e.e2) begin
          n_err++;
          $display("FAIL %s: RData1=%h RData2=%h, expected RData1=%h RData2=%h",
                   e.name, grf_if.GRF_RData1, grf_if.GRF_RData2, e.e1, e.e2);
        end else begin
          $display("ok   %s: RData1=%h RData2=%h", e.name, grf_if.GRF_RData1, grf_if.GRF_RData2);
        end
      end
    end
  end

  task automatic check(input string name, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk);
    grf_if.GRF_RAddr1 = a1;
    grf_if.GRF_RAddr2 = a2;
    #1;
    push_exp(name, e1, e2);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    grf_if.GRF_WEnable = 1'b1;
    grf_if.GRF_WAddr   = addr;
    grf_if.GRF_WData   = data;
    @(posedge clk);
    #1;
    grf_if.GRF_WEnable = 1'b0;
  endtask

  initial begin : stimulus
    reset              = 1'b0;
    grf_if.GRF_WEnable = 1'b0;
    grf_if.GRF_WAddr   = '0;
    grf_if.GRF_WData   = '0;
    grf_if.GRF_RAddr1  = '0;
    grf_if.GRF_RAddr2  = '0;

    // 1: reset for a cycle, then every index reads zero on both ports
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("reset_idx%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    // 2: $0 cannot be written
    do_write(5'd0, 32'd1234);
    check("write_r0", 5'd0, 5'd0, 32'h0, 32'h0);

    // 3: disabled write leaves $15 untouched
    @(negedge clk);
    grf_if.GRF_WEnable = 1'b0;
    grf_if.GRF_WAddr   = 5'd15;
    grf_if.GRF_WData   = 32'd1234;
    @(posedge clk);
    check("we0_r15", 5'd15, 5'd0, 32'h0, 32'h0);

    // 4: read-during-write without bypass: old value before edge, new after
    @(negedge clk);
    grf_if.GRF_WEnable = 1'b1;
    grf_if.GRF_WAddr   = 5'd16;
    grf_if.GRF_WData   = 32'd3411;
    grf_if.GRF_RAddr1  = 5'd16;
    grf_if.GRF_RAddr2  = 5'd16;
    #1;
    push_exp("rdw_before_edge", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    push_exp("rdw_after_edge", 32'd3411, 32'd3411);
    grf_if.GRF_WEnable = 1'b0;
    check("r16_hold", 5'd16, 5'd15, 32'd3411, 32'h0);

    // 5: asynchronous reset mid-cycle clears immediately, stays clear after release
    @(negedge clk);
    grf_if.GRF_RAddr1 = 5'd16;
    grf_if.GRF_RAddr2 = 5'd16;
    #1;
    push_exp("pre_async_reset", 32'd3411, 32'd3411);
    #1;
    reset = 1'b0;
    #1;
    push_exp("async_reset_now", 32'h0, 32'h0);
    #1;
    reset = 1'b1;
    check("after_release", 5'd16, 5'd16, 32'h0, 32'h0);

    // writes with reset held across the edge are ignored
    @(negedge clk);
    reset              = 1'b0;
    grf_if.GRF_WEnable = 1'b1;
    grf_if.GRF_WAddr   = 5'd5;
    grf_if.GRF_WData   = 32'h0000_00AA;
    @(posedge clk);
    #1;
    grf_if.GRF_WEnable = 1'b0;
    reset              = 1'b1;
    check("write_in_reset", 5'd5, 5'd5, 32'h0, 32'h0);

    // 6: both ports read distinct registers at once
    do_write(5'd31, 32'hDEAD_BEEF);
    do_write(5'd1,  32'h0000_0001);
    check("dual_read", 5'd31, 5'd1, 32'hDEAD_BEEF, 32'h0000_0001);
    check("swap_ports", 5'd1, 5'd31, 32'h0000_0001, 32'hDEAD_BEEF);
    check("same_addr", 5'd31, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // overwrite and neighbour isolation
    do_write(5'd31, 32'h1234_5678);
    do_write(5'd30, 32'hFFFF_FFFF);
    check("overwrite_r31", 5'd31, 5'd30, 32'h1234_5678, 32'hFFFF_FFFF);
    check("r1_kept", 5'd1, 5'd0, 32'h0000_0001, 32'h0);
    check("r2_clear", 5'd2, 5'd29, 32'h0, 32'h0);

    begin
      int budget = 100;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_err++;
        $display("FAIL drain: %0d entries unchecked, required 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
